// File: rtl/memory_sync.sv
// Single-port synchronous RAM with a valid/ready request handshake.
// One read or write per accepted request; ready and rdata are registered.
module memory_sync #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 256,
    parameter int ADDR  = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [ADDR-1:0]  i_addr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_wrbar,
    input  logic             i_valid,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_ready
);

    // Handshake: every cycle with i_valid=1 and i_rst=0 is accepted at that
    // edge (no wait states); o_ready is high for the following cycle only.
    localparam logic [ADDR:0] LP_DEPTH = (ADDR + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [DEPTH-1:0] r_written;
    logic [WIDTH-1:0] r_rdata;
    logic             r_ready;

    logic             w_in_range;
    logic             w_do_write;
    logic             w_do_read;
    logic [WIDTH-1:0] w_read_word;

    assign w_in_range = ({1'b0, i_addr} < LP_DEPTH);
    assign w_do_write = i_valid & i_wrbar & w_in_range;
    assign w_do_read  = i_valid & ~i_wrbar;

    // Unwritten locations read as zero, so a reset only has to clear the
    // per-word written flags instead of every data word.
    always_comb begin
        w_read_word = '0;
        if (w_in_range && r_written[i_addr]) begin
            w_read_word = r_mem[i_addr];
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst && w_do_write) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_written <= '0;
            r_rdata   <= '0;
            r_ready   <= 1'b0;
        end else begin
            r_ready <= i_valid;
            if (w_do_write) begin
                r_written[i_addr] <= 1'b1;
            end
            if (w_do_read) begin
                r_rdata <= w_read_word;
            end
        end
    end

    assign o_rdata = r_rdata;
    assign o_ready = r_ready;

endmodule

// File: tb/tb_memory_sync.sv
// Randomized scoreboard bench for memory_sync: a driver updates a
// behavioural memory model per edge, a monitor checks ready/rdata per cycle.
module tb_memory_sync;

    localparam int WIDTH = 32;
    localparam int DEPTH = 256;
    localparam int ADDR  = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             valid;
    logic             wrbar;
    logic [ADDR-1:0]  addr;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] rdata;
    logic             ready;

    int checks = 0;
    int errors = 0;

    logic [WIDTH-1:0] exp_q[$];
    logic             exp_rdy_q[$];

    logic [WIDTH-1:0] model_mem[int];
    logic [WIDTH-1:0] model_rdata = '0;

    always #5 clk = ~clk;

    memory_sync #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR(ADDR)) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_addr  (addr),
        .i_wdata (wdata),
        .i_wrbar (wrbar),
        .i_valid (valid),
        .o_rdata (rdata),
        .o_ready (ready)
    );

    // One clock cycle of stimulus; the model applies the edge's effect and
    // queues the outputs expected for the cycle after that edge.
    task automatic cycle(input logic r, input logic v, input logic w,
                         input int a, input logic [WIDTH-1:0] d);
        rst   = r;
        valid = v;
        wrbar = w;
        addr  = a[ADDR-1:0];
        wdata = d;
        @(posedge clk);
        if (r) begin
            model_mem.delete();
            model_rdata = '0;
        end else if (v) begin
            if (w) begin
                if (a < DEPTH) model_mem[a] = d;
            end else begin
                if (a < DEPTH && model_mem.exists(a)) model_rdata = model_mem[a];
                else model_rdata = '0;
            end
        end
        exp_q.push_back(model_rdata);
        exp_rdy_q.push_back(!r && v);
        @(negedge clk);
    endtask

    task automatic wr(input int a, input logic [WIDTH-1:0] d);
        cycle(1'b0, 1'b1, 1'b1, a, d);
    endtask

    task automatic rd(input int a);
        cycle(1'b0, 1'b1, 1'b0, a, $urandom());
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, 1'($urandom_range(0, 1)), $urandom_range(0, DEPTH - 1), $urandom());
    endtask

    task automatic reset_cycle(input logic v);
        cycle(1'b1, v, 1'b1, $urandom_range(0, DEPTH - 1), $urandom());
    endtask

    // Master that keeps valid up until it sees ready: the request executes twice.
    task automatic wr_held(input int a, input logic [WIDTH-1:0] d);
        wr(a, d);
        wr(a, d);
    endtask

    task automatic rd_held(input int a);
        rd(a);
        rd(a);
    endtask

    always @(negedge clk) begin
        logic [WIDTH-1:0] e;
        logic             er;
        if (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            er = exp_rdy_q.pop_front();
            checks++;
            if (ready !== er) begin
                errors++;
                $display("FAIL ready t=%0t actual=%0b expected=%0b", $time, ready, er);
            end
            checks++;
            if (rdata !== e) begin
                errors++;
                $display("FAIL rdata t=%0t actual=%08h expected=%08h", $time, rdata, e);
            end
        end
    end

    initial begin
        int sizes[4];
        int n;
        sizes[0] = DEPTH / 8;
        sizes[1] = DEPTH / 4;
        sizes[2] = DEPTH / 2;
        sizes[3] = DEPTH;

        // Reset held two cycles with a write request present, then read 0x05.
        reset_cycle(1'b1);
        reset_cycle(1'b1);
        rd(5);
        idle();

        // Single write/read, then read-after-write on consecutive edges.
        wr(8'h10, 32'hDEADBEEF);
        idle();
        rd(8'h10);
        wr(8'h11, 32'hCAFEF00D);
        rd(8'h11);
        rd(8'h10);

        // Boundaries: no aliasing between 0 and DEPTH-1.
        wr(0, 32'h0000_0001);
        wr(DEPTH - 1, 32'hFFFF_FFFE);
        rd(0);
        rd(DEPTH - 1);
        wr(0, 32'h1357_9BDF);
        rd(DEPTH - 1);
        rd(0);

        // Idle/hold after a read.
        wr(8'h40, 32'h12345678);
        rd(8'h40);
        idle();
        idle();
        idle();

        // Reset mid-operation clears memory.
        wr(3, 32'hA5A5A5A5);
        reset_cycle(1'b0);
        rd(3);
        idle();

        // Sweeps over growing ranges with held and back-to-back requests.
        for (int s = 0; s < 4; s++) begin
            n = sizes[s];
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 3) == 0) wr_held(i, $urandom());
                else wr(i, $urandom());
                if ($urandom_range(0, 7) == 0) idle();
            end
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 3) == 0) rd_held(i);
                else rd(i);
                if ($urandom_range(0, 7) == 0) idle();
            end
        end

        // Random mix including occasional resets.
        for (int i = 0; i < 600; i++) begin
            case ($urandom_range(0, 19))
                0:               reset_cycle(1'($urandom_range(0, 1)));
                1, 2, 3:         idle();
                4, 5, 6, 7, 8:   wr($urandom_range(0, DEPTH - 1), $urandom());
                9:               wr_held($urandom_range(0, DEPTH - 1), $urandom());
                10:              rd_held($urandom_range(0, DEPTH - 1));
                default:         rd($urandom_range(0, DEPTH - 1));
            endcase
        end
        idle();

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain remaining=%0d expected=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
